// File: rtl/nibble_rx_pkg.sv
// nibble_rx_pkg: shared types and helpers for the nibble_rx serial receiver.
// Optional feature macro: NIBBLE_RX_PARITY_EN (adds an even-parity bit per frame).
package nibble_rx_pkg;

  // Receiver FSM states; PARITY is only reachable when parity is enabled.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  // Default payload width, matching the downstream encoder_decoder input.
  localparam int DATA_W_DEF = 4;

  // Even-parity bit for a zero-extended word: XOR of word and result is 0.
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/nibble_out_reg.sv
// nibble_out_reg: hold register with valid/ready handshake. Decides whether a
// good word loads or is dropped, and keeps the sticky overrun flag.
module nibble_out_reg #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              word_valid_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              out_ready_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              overrun_o,
  output logic              accept_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              drop;

  // Load when empty or when the held word is consumed in this same cycle.
  always_comb begin
    accept_o  = word_valid_i & (~valid_q | out_ready_i);
    drop      = word_valid_i & ~accept_o;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (accept_o) begin
      data_d  = word_i;
      valid_d = 1'b1;
    end else if (valid_q & out_ready_i) begin
      valid_d = 1'b0;
    end
    // A new overrun takes priority over a clear in the same cycle.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (err_clr_i) begin
      overrun_d = 1'b0;
    end
  end

  // Hold-register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/nibble_rx.sv
// nibble_rx: framed serial-to-parallel receiver (start, DATA_W bits LSB first,
// optional even parity, stop). Build option: define NIBBLE_RX_PARITY_EN to
// add the parity bit and its check.
module nibble_rx
  import nibble_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_valid,
  input  logic              serial_in,
  input  logic              out_ready,
  input  logic              err_clr,
  output logic [DATA_W-1:0] binary_input,
  output logic              out_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic [CNT_W-1:0]  word_count
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              shift_en, eval_en, par_cap;
  logic              parity_ok, frame_good, accept;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: advances only on bit strobes.
  always_comb begin
    state_d = state_q;
    if (bit_valid) begin
      case (state_q)
        IDLE:    if (!serial_in) state_d = DATA;
        DATA: begin
          if (idx_q == LAST_IDX) begin
`ifdef NIBBLE_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: per-strobe action decode.
  always_comb begin
    shift_en = 1'b0;
    par_cap  = 1'b0;
    eval_en  = 1'b0;
    if (bit_valid) begin
      case (state_q)
        DATA:    shift_en = 1'b1;
        PARITY:  par_cap  = 1'b1;
        STOP:    eval_en  = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath next values: bits enter at the MSB so the first bit ends at bit 0.
  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (bit_valid && state_q == IDLE) begin
      idx_d = '0;
    end else if (shift_en) begin
      idx_d   = idx_q + 1'b1;
      shift_d = {serial_in, shift_q[DATA_W-1:1]};
    end
  end

`ifdef NIBBLE_RX_PARITY_EN
  logic parity_q;

  // Captured parity bit of the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       parity_q <= 1'b0;
    else if (par_cap) parity_q <= serial_in;
  end

  assign parity_ok = (even_parity({{(32-DATA_W){1'b0}}, shift_q}) == parity_q);
`else
  assign parity_ok = 1'b1;
`endif

  // Frame verdict on the stop strobe; the stop bit is the live serial_in.
  always_comb begin
    frame_good  = eval_en & serial_in & parity_ok;
    frame_err_d = eval_en & ~(serial_in & parity_ok);
    count_d     = accept ? count_q + 1'b1 : count_q;
  end

  // Shift register, bit index, error pulse and accepted-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      count_q     <= '0;
    end else begin
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      count_q     <= count_d;
    end
  end

  nibble_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .word_valid_i (frame_good),
    .word_i       (shift_q),
    .out_ready_i  (out_ready),
    .err_clr_i    (err_clr),
    .data_o       (binary_input),
    .valid_o      (out_valid),
    .overrun_o    (overrun),
    .accept_o     (accept)
  );

  assign frame_err  = frame_err_q;
  assign word_count = count_q;

endmodule
